// File: rtl/utils_pkg.sv
// Shared types for the packet datapath: OutFIFO status/command, UDP lengths and the TX scheduler FSM.
package utils_pkg;

  localparam int OUTFIFO_KB_SIZE = 4;
  localparam int PTR_W           = 16;

  typedef logic [15:0]      udp_length_t;
  typedef logic [PTR_W-1:0] ptr_t;

  localparam udp_length_t OUTFIFO_BYTES = udp_length_t'(OUTFIFO_KB_SIZE * 1024);

  typedef struct packed {
    ptr_t rd_ptr;
    ptr_t wr_ptr;
    logic empty;
    logic full;
    logic done;
  } s_fifo_st_t;

  typedef struct packed {
    logic        start;
    udp_length_t length;
    logic        clear;
  } s_fifo_cmd_t;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_CHECK,
    TX_WAIT_DATA,
    TX_HDR,
    TX_STREAM,
    TX_RELEASE,
    TX_ABORT
  } tx_sched_st_t;

  // A request is sendable only if it is non-empty and fits in the OutFIFO.
  function automatic logic len_is_valid(input udp_length_t len);
    return (len != '0) && (len <= OUTFIFO_BYTES);
  endfunction

endpackage

// File: rtl/eth_fifo.sv
// Small request queue: wrap-bit pointers, head visible combinationally, synchronous flush.
module eth_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]      count;
  logic [WIDTH-1:0] slot_reg [DEPTH];
  logic             push_ok, pop_ok;

  assign count   = wr_ptr_reg - rd_ptr_reg;
  assign empty_o = (count == '0);
  assign full_o  = (count == (AW+1)'(DEPTH));
  // A flush wins over anything offered in the same cycle.
  assign push_ok = push_i && !full_o && !clear_i;
  assign pop_ok  = pop_i && !empty_o && !clear_i;
  assign head_o  = slot_reg[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push_ok) slot_reg[wr_ptr_reg[AW-1:0]] <= data_i;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else if (clear_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

endmodule

// File: rtl/eth_tx_sched.sv
// Transmit scheduler: queues send requests, waits for OutFIFO payload, issues the UDP header
// request and sequences the OutFIFO start/length/clear command through one packet stream.
module eth_tx_sched
  import utils_pkg::*;
#(
  parameter int REQ_SLOTS      = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  input  udp_length_t req_length_i,
  output logic        req_ready_o,
  input  logic        sw_clear_i,
  input  s_fifo_st_t  fifo_st_i,
  output s_fifo_cmd_t fifo_cmd_o,
  output logic        hdr_valid_o,
  output udp_length_t hdr_length_o,
  input  logic        hdr_ready_i,
  output logic        busy_o,
  output logic        err_o,
  output logic [15:0] sent_cnt_o
);

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  tx_sched_st_t state_reg, state_next;
  logic [15:0]  tmo_cnt_reg, sent_cnt_reg;
  logic         flush_reg, err_reg, err_next, ready_en_reg;
  logic         q_pop, q_empty, q_full;
  udp_length_t  cur_len;
  ptr_t         occupancy;
  logic         unused_fifo_flags;

  assign occupancy         = fifo_st_i.wr_ptr - fifo_st_i.rd_ptr;
  assign unused_fifo_flags = fifo_st_i.empty ^ fifo_st_i.full;

  eth_fifo #(
    .DEPTH (REQ_SLOTS),
    .WIDTH ($bits(udp_length_t))
  ) u_req_q (
    .clk     (clk),
    .rst     (rst),
    .clear_i (sw_clear_i),
    .push_i  (req_valid_i && req_ready_o),
    .data_i  (req_length_i),
    .pop_i   (q_pop),
    .head_o  (cur_len),
    .empty_o (q_empty),
    .full_o  (q_full)
  );

  always_comb begin
    state_next = state_reg;
    q_pop      = 1'b0;
    err_next   = 1'b0;
    case (state_reg)
      TX_IDLE: if (!q_empty) state_next = TX_CHECK;
      TX_CHECK: begin
        if (!len_is_valid(cur_len)) begin
          q_pop      = 1'b1;
          err_next   = 1'b1;
          state_next = TX_IDLE;
        end else begin
          state_next = TX_WAIT_DATA;
        end
      end
      TX_WAIT_DATA: if (occupancy >= cur_len) state_next = TX_HDR;
      TX_HDR:       if (hdr_ready_i) state_next = TX_STREAM;
      TX_STREAM: begin
        if (fifo_st_i.done) begin
          state_next = TX_RELEASE;
        end else if (tmo_cnt_reg >= TMO_LAST) begin
          state_next = TX_ABORT;
          err_next   = 1'b1;
        end
      end
      TX_RELEASE: begin
        q_pop      = 1'b1;
        state_next = TX_IDLE;
      end
      TX_ABORT: begin
        q_pop      = 1'b1;
        state_next = TX_IDLE;
      end
      default: state_next = TX_IDLE;
    endcase
    // Software flush overrides every event seen in the same cycle.
    if (sw_clear_i) begin
      state_next = TX_IDLE;
      q_pop      = 1'b0;
      err_next   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= TX_IDLE;
      tmo_cnt_reg  <= '0;
      sent_cnt_reg <= '0;
      flush_reg    <= 1'b0;
      err_reg      <= 1'b0;
      ready_en_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      flush_reg    <= sw_clear_i;
      err_reg      <= err_next;
      ready_en_reg <= 1'b1;
      if (state_reg == TX_RELEASE && !sw_clear_i) sent_cnt_reg <= sent_cnt_reg + 16'd1;
      if (state_reg != TX_STREAM) tmo_cnt_reg <= '0;
      else if (tmo_cnt_reg != '1) tmo_cnt_reg <= tmo_cnt_reg + 16'd1;
    end
  end

  always_comb begin
    fifo_cmd_o        = '0;
    fifo_cmd_o.start  = (state_reg == TX_STREAM);
    fifo_cmd_o.length = (state_reg == TX_STREAM) ? cur_len : '0;
    fifo_cmd_o.clear  = flush_reg || (state_reg == TX_ABORT);
  end

  assign req_ready_o  = ready_en_reg && !q_full;
  assign hdr_valid_o  = (state_reg == TX_HDR);
  assign hdr_length_o = (state_reg == TX_HDR) ? cur_len : '0;
  assign busy_o       = (state_reg != TX_IDLE) || !q_empty;
  assign err_o        = err_reg;
  assign sent_cnt_o   = sent_cnt_reg;

endmodule

// File: doc/eth_tx_sched.md
# eth_tx_sched

Transmit scheduler for the OutFIFO packet buffer. It queues software send requests (payload length in bytes) and waits until the OutFIFO holds enough payload. It then hands a UDP header request to the UDP stack and sequences the OutFIFO `fifo_cmd` start/length/clear fields through one complete packet stream. It sits between the CSR block and the OutFIFO instance of `pkt_fifo`, and is the only driver of that instance's `fifo_cmd_i`.

## Interface
- `REQ_SLOTS`, 4: depth of the pending-request queue (power of two, ≥2).
- `TIMEOUT_CYCLES`, 65535: maximum cycles allowed in STREAM before the packet is aborted.
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  reset, asynchronous assert, active-low.
- `req_valid_i`  in  1  send request valid.
- `req_length_i`  in  `udp_length_t`  payload bytes for the request.
- `req_ready_o`  out  1  queue not full; a request is accepted when valid and ready are both high.
- `sw_clear_i`  in  1  flush request (one-cycle pulse from CSR).
- `fifo_st_i`  in  `s_fifo_st_t`  OutFIFO status: `rd_ptr`, `wr_ptr`, `empty`, `full`, `done`.
- `fifo_cmd_o`  out  `s_fifo_cmd_t`  OutFIFO command: `start`, `length`, `clear`.
- `hdr_valid_o`  out  1  UDP header request valid.
- `hdr_length_o`  out  `udp_length_t`  payload length for the header.
- `hdr_ready_i`  in  1  UDP stack accepts the header.
- `busy_o`  out  1  state is not IDLE, or the queue is not empty.
- `err_o`  out  1  one-cycle pulse on a rejected request or a timeout abort.
- `sent_cnt_o`  out  16  packets completed; wraps modulo 2^16.

## Operation
- Request queue: `eth_fifo` of `REQ_SLOTS` × `$bits(udp_length_t)`. The head entry is `cur_len`.
- Occupancy is `wr_ptr - rd_ptr`, computed in `ptr_t` width with modulo arithmetic, so pointer wrap is transparent.
- FSM states: IDLE, CHECK, WAIT_DATA, HDR, STREAM, RELEASE, ABORT.
- IDLE → CHECK when the queue is not empty.
- CHECK:
  - If `cur_len == 0` or `cur_len > OUTFIFO_KB_SIZE*1024`: pop the entry, pulse `err_o`, go to IDLE.
  - Otherwise go to WAIT_DATA.
- WAIT_DATA → HDR when occupancy ≥ `cur_len`.
- HDR:
  - `hdr_valid_o`=1 and `hdr_length_o`=`cur_len`, both held stable until `hdr_ready_i`.
  - On the handshake cycle, go to STREAM.
- STREAM:
  - `fifo_cmd_o.start`=1 and `fifo_cmd_o.length`=`cur_len`, held stable for the whole state.
  - The timeout counter increments each cycle.
  - When `fifo_st_i.done`=1, go to RELEASE.
  - If the counter reaches `TIMEOUT_CYCLES` without `done`, go to ABORT.
- RELEASE:
  - `start`=0 for exactly one cycle, so the OutFIFO returns from DONE to IDLE.
  - Pop the request and increment `sent_cnt_o`.
  - Go to IDLE.
- ABORT:
  - `fifo_cmd_o.clear`=1 for one cycle, `start`=0.
  - Pop the request, pulse `err_o`.
  - Go to IDLE.
- `sw_clear_i`, from any state:
  - Next cycle: `clear`=1 for one cycle, `start`=0, `hdr_valid_o`=0.
  - The queue is flushed and the FSM goes to IDLE.
  - A request offered in the same cycle is dropped.
  - `sent_cnt_o` is unchanged.
  - `sw_clear_i` takes priority over done, timeout and handshake events in the same cycle.
- A request push and a pop in the same cycle are both honoured; the queue count is unchanged.

## Timing
- Reset values: `req_ready_o`=0 while `rst` is low, 1 after release. All other outputs 0, FSM in IDLE, counters 0.
- All outputs are registered or decoded from state only; there is no combinational path from `fifo_st_i` or `hdr_ready_i` to any output.
- Minimum latency, request accepted to `start` rising, with data already present:
  - cycle 1: queue not empty
  - cycle 2: CHECK
  - cycle 3: WAIT_DATA
  - cycle 4: `hdr_valid_o` asserted
  - `start` rises the cycle after the header handshake.
- `start` falls the cycle after `done` is sampled. The next packet cannot assert `start` earlier than 4 cycles after that.
- The timeout counter is 16 bits, cleared on entry to STREAM, and saturates.
- Asserting `rst` mid-packet drops `start` immediately and asynchronously. The OutFIFO is reset by the same `rst`.

## Structure
- Add `tx_sched_st_t` (the FSM enum) to `utils_pkg`.
- Reuse the existing `utils_pkg` types: `udp_length_t`, `ptr_t`, `s_fifo_st_t`, `s_fifo_cmd_t`, `OUTFIFO_KB_SIZE`.
- One sub-module: `eth_fifo` for the request queue, with `clear_i` driven by `sw_clear_i`.

## Test plan
- Single packet: push len=64 with occupancy already 64 → `hdr_valid_o` with `hdr_length_o`=64; after `hdr_ready_i`, `start`=1 and `length`=64 until `done`; then one cycle `start`=0; `sent_cnt_o`=1.
- Data starvation: push len=100 with occupancy 40, then write 60 more bytes → no `hdr_valid_o` until occupancy reaches 100.
- Back-to-back and full queue: push 5 requests (10, 20, 30, 40, 50) with `REQ_SLOTS`=4 → `req_ready_o`=0 after the 4th push; the 5th is accepted once the first pops; packets go out in order; `sent_cnt_o`=5.
- Rejects: push len=0, then len=`OUTFIFO_KB_SIZE*1024`+1 → each gives an `err_o` pulse with no `hdr_valid_o` and no `start`; `sent_cnt_o` unchanged.
- Timeout: `TIMEOUT_CYCLES`=16, hold the sink `tready`=0 → after 16 STREAM cycles, `clear`=1 for one cycle, `err_o` pulses, FSM back in IDLE.
- Flush mid-stream: `sw_clear_i` during STREAM with 2 requests queued → `start`=0 and `clear`=1 on the next cycle, queue empty, `busy_o`=0.
